// File: rtl/decompress_unit.sv
// decompress_unit: unpacks LSB-first d-bit coefficients from API words,
// applies Decompress_d (d12 passes through) and writes 4 coefficients/clk.
module decompress_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_W    = 15,
    parameter int REG_SIZE      = 24,
    parameter int COEFF_PER_CLK = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              zeroize,
    input  logic                              decompress_enable,
    input  logic [1:0]                        mode,
    input  logic [2:0]                        num_poly,
    input  logic [MEM_ADDR_W-1:0]             src_base_addr,
    input  logic [MEM_ADDR_W-1:0]             dest_base_addr,
    output logic                              api_rd_en,
    output logic [MEM_ADDR_W-1:0]             api_rd_addr,
    input  logic [DATA_WIDTH-1:0]             api_rd_data,
    output logic                              mem_wr_en,
    output logic [MEM_ADDR_W-1:0]             mem_wr_addr,
    output logic [COEFF_PER_CLK*REG_SIZE-1:0] mem_wr_data,
    output logic                              decode_error,
    output logic                              decompress_done
);

    localparam int BUF_W  = 3 * DATA_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int CNT_W  = 10;
    localparam int DATA_W = COEFF_PER_CLK * REG_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q;
    logic [FILL_W-1:0]     pop_bits_q;
    logic [CNT_W-1:0]      words_total_q, writes_total_q;
    logic [CNT_W-1:0]      word_cnt_q, pop_cnt_q;
    logic [MEM_ADDR_W-1:0] src_q, dest_q;
    logic [BUF_W-1:0]      bit_buf_q;
    logic [FILL_W-1:0]     fill_q;
    logic                  rd_pend_q;
    logic                  wr_en_q, wr_last_q, err_q;
    logic [MEM_ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;

    logic              start, active, pop, issue, err_hit;
    logic [2:0]        np_eff;
    logic [6:0]        wpp;
    logic [FILL_W-1:0] pop_bits_d;
    logic [BUF_W-1:0]  word_ext, merged;
    logic [FILL_W-1:0] avail, fill_after;
    logic [11:0]       x;
    logic [DATA_W-1:0] coeff_data;

    function automatic logic [11:0] decomp(input logic [1:0] m, input logic [11:0] v);
        logic [23:0] p;
        p = 24'(v) * 24'd3329;
        case (m)
            2'd0:    decomp = 12'((p + 24'd1) >> 1);
            2'd1:    decomp = 12'((p + 24'd16) >> 5);
            2'd2:    decomp = 12'((p + 24'd1024) >> 11);
            default: decomp = v;
        endcase
    endfunction

    // Command parameters captured at start
    always_comb begin
        np_eff = (num_poly == 3'd0) ? 3'd1 : num_poly;
        wpp = 7'd8;
        pop_bits_d = FILL_W'(COEFF_PER_CLK);
        case (mode)
            2'd0: begin wpp = 7'd8;  pop_bits_d = FILL_W'(COEFF_PER_CLK * 1);  end
            2'd1: begin wpp = 7'd40; pop_bits_d = FILL_W'(COEFF_PER_CLK * 5);  end
            2'd2: begin wpp = 7'd88; pop_bits_d = FILL_W'(COEFF_PER_CLK * 11); end
            default: begin wpp = 7'd96; pop_bits_d = FILL_W'(COEFF_PER_CLK * 12); end
        endcase
    end

    // The arriving word is merged above the current fill before any pop
    always_comb begin
        start      = (state_q == S_IDLE) && decompress_enable;
        active     = (state_q == S_RUN) || (state_q == S_DRAIN);
        word_ext   = rd_pend_q ? (BUF_W'(api_rd_data) << fill_q) : '0;
        merged     = bit_buf_q | word_ext;
        avail      = fill_q + (rd_pend_q ? FILL_W'(DATA_WIDTH) : '0);
        pop        = active && (avail >= pop_bits_q) &&
                     (pop_cnt_q < writes_total_q);
        fill_after = pop ? (avail - pop_bits_q) : avail;
        issue      = (state_q == S_RUN) && (word_cnt_q < words_total_q) &&
                     (fill_after <= FILL_W'(BUF_W - DATA_WIDTH));
    end

    always_comb begin
        err_hit    = 1'b0;
        coeff_data = '0;
        x          = '0;
        for (int k = 0; k < COEFF_PER_CLK; k++) begin
            case (mode_q)
                2'd0:    x = 12'(merged[k]);
                2'd1:    x = 12'(merged[k*5 +: 5]);
                2'd2:    x = 12'(merged[k*11 +: 11]);
                default: x = merged[k*12 +: 12];
            endcase
            coeff_data[k*REG_SIZE +: REG_SIZE] = REG_SIZE'(decomp(mode_q, x));
            if ((mode_q == 2'd3) && (x >= 12'd3329)) err_hit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (decompress_enable) state_d = S_RUN;
            S_RUN:   if (issue && (word_cnt_q == words_total_q - CNT_W'(1)))
                         state_d = S_DRAIN;
            S_DRAIN: if (wr_en_q && wr_last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            state_q        <= S_IDLE;
            mode_q         <= '0;
            pop_bits_q     <= '0;
            words_total_q  <= '0;
            writes_total_q <= '0;
            word_cnt_q     <= '0;
            pop_cnt_q      <= '0;
            src_q          <= '0;
            dest_q         <= '0;
            bit_buf_q      <= '0;
            fill_q         <= '0;
            rd_pend_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_last_q      <= 1'b0;
            err_q          <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_buf_q <= pop ? (merged >> pop_bits_q) : merged;
            fill_q    <= fill_after;
            rd_pend_q <= issue;
            wr_en_q   <= pop;
            if (issue) word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + CNT_W'(1);
                wr_addr_q <= dest_q + MEM_ADDR_W'(pop_cnt_q);
                wr_data_q <= coeff_data;
                wr_last_q <= (pop_cnt_q == writes_total_q - CNT_W'(1));
                if (err_hit) err_q <= 1'b1;
            end
            if (start) begin
                mode_q         <= mode;
                pop_bits_q     <= pop_bits_d;
                words_total_q  <= CNT_W'(wpp) * CNT_W'(np_eff);
                writes_total_q <= CNT_W'({np_eff, 6'b0});
                word_cnt_q     <= '0;
                pop_cnt_q      <= '0;
                src_q          <= src_base_addr;
                dest_q         <= dest_base_addr;
                err_q          <= 1'b0;
            end
        end
    end

    assign api_rd_en       = issue;
    assign api_rd_addr     = src_q + MEM_ADDR_W'(word_cnt_q);
    assign mem_wr_en       = wr_en_q;
    assign mem_wr_addr     = wr_addr_q;
    assign mem_wr_data     = wr_data_q;
    assign decode_error    = err_q;
    assign decompress_done = (state_q == S_DONE);

endmodule

// File: tb/tb_decompress_unit.sv
// tb_decompress_unit: randomized bench for decompress_unit, checked against
// a bit-stream model of the unpack and Decompress_d rules.
`timescale 1ns/1ps
module tb_decompress_unit;
    localparam int AW = 15;
    localparam int AS = 32768;

    logic          clk = 1'b0;
    logic          reset, zeroize, decompress_enable;
    logic [1:0]    mode;
    logic [2:0]    num_poly;
    logic [AW-1:0] src_base_addr, dest_base_addr;
    logic          api_rd_en;
    logic [AW-1:0] api_rd_addr;
    logic [31:0]   api_rd_data = '0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [95:0]   mem_wr_data;
    logic          decode_error, decompress_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] api_mem [0:AS-1];
    logic [31:0] words_q[$];
    int          wr_addr_q[$];
    logic [95:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          rd_addr_q[$];
    int          rd_cyc_q[$];
    int          done_q[$];
    int          exp_coeff[$];
    logic        exp_err;

    always #5 clk = ~clk;

    decompress_unit dut (
        .clk(clk), .reset(reset), .zeroize(zeroize),
        .decompress_enable(decompress_enable), .mode(mode),
        .num_poly(num_poly), .src_base_addr(src_base_addr),
        .dest_base_addr(dest_base_addr), .api_rd_en(api_rd_en),
        .api_rd_addr(api_rd_addr), .api_rd_data(api_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .decode_error(decode_error),
        .decompress_done(decompress_done)
    );

    // API memory: data valid one cycle after the read strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (api_rd_en) api_rd_data <= api_mem[api_rd_addr];
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_addr_q.push_back(int'(mem_wr_addr));
            wr_data_q.push_back(mem_wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (api_rd_en) begin
            rd_addr_q.push_back(int'(api_rd_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (decompress_done) done_q.push_back(cyc);
    end

    function automatic int dval(input int m);
        return (m == 0) ? 1 : (m == 1) ? 5 : (m == 2) ? 11 : 12;
    endfunction

    // Treat the words as one LSB-first bit string and cut d-bit fields
    task automatic build_model(input int m, input int np);
        int d, xv, bp;
        logic [31:0] w;
        d = dval(m);
        exp_coeff.delete();
        exp_err = 1'b0;
        for (int i = 0; i < 256 * np; i++) begin
            xv = 0;
            for (int b = 0; b < d; b++) begin
                bp = i * d + b;
                w = words_q[bp / 32];
                if (w[bp % 32]) xv += (1 << b);
            end
            if (d == 12) begin
                if (xv >= 3329) exp_err = 1'b1;
                exp_coeff.push_back(xv);
            end else begin
                exp_coeff.push_back((3329 * xv + (1 << (d - 1))) >> d);
            end
        end
    endtask

    task automatic gen_words(input int m, input int np, input int kind);
        words_q.delete();
        for (int i = 0; i < 8 * dval(m) * np; i++)
            words_q.push_back((kind == 0) ? $urandom : 32'h0);
    endtask

    function automatic int bad_writes(input int dest);
        int n;
        logic [95:0] e;
        n = 0;
        for (int j = 0; j < wr_data_q.size(); j++) begin
            e = '0;
            for (int k = 0; k < 4; k++)
                if (4 * j + k < exp_coeff.size())
                    e[k*24 +: 24] = 24'(exp_coeff[4 * j + k]);
            if (wr_data_q[j] !== e || wr_addr_q[j] != (dest + j) % AS) n++;
        end
        return n;
    endfunction

    function automatic int bad_reads(input int src);
        int n;
        n = 0;
        for (int i = 0; i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] != (src + i) % AS) n++;
        return n;
    endfunction

    function automatic int last_wr();
        return (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : -100;
    endfunction

    task automatic start_cmd(input int m, input int np, input int src, input int dest);
        for (int i = 0; i < words_q.size(); i++) api_mem[(src + i) % AS] = words_q[i];
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete(); done_q.delete();
        @(negedge clk);
        mode = 2'(m);
        num_poly = 3'(np);
        src_base_addr = AW'(src);
        dest_base_addr = AW'(dest);
        decompress_enable = 1'b1;
        @(negedge clk);
        decompress_enable = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_q.size() > 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; zeroize = 1'b0; decompress_enable = 1'b0;
        mode = 2'd0; num_poly = 3'd1; src_base_addr = '0; dest_base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({api_rd_en, mem_wr_en, decompress_done, decode_error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {api_rd_en, mem_wr_en, decompress_done, decode_error});
        end
        checks++;
        if ({api_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h/%h want 0", api_rd_addr, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({api_rd_en, mem_wr_en, decompress_done} !== 3'b0) begin
            errors++;
            $display("FAIL idle_quiet got %b want 000", {api_rd_en, mem_wr_en, decompress_done});
        end
    endtask

    task automatic test_d1();
        bit to;
        int src, dest;
        src = 100; dest = 2000;
        words_q.delete();
        for (int i = 0; i < 8; i++) words_q.push_back(32'hAAAAAAAA);
        build_model(0, 1);
        start_cmd(0, 1, src, dest);
        wait_done(400, to);
        checks++; if (to) begin errors++; $display("FAIL d1_timeout got timeout want done"); end
        checks++; if (wr_data_q.size() != 64) begin errors++; $display("FAIL d1_writes got %0d want 64", wr_data_q.size()); end
        checks++; if (wr_data_q.size() > 0 && wr_data_q[0] !== {24'd1665, 24'd0, 24'd1665, 24'd0}) begin
            errors++; $display("FAIL d1_write0 got %h want 1665/0 pattern", wr_data_q[0]); end
        checks++; if (bad_writes(dest) != 0) begin errors++; $display("FAIL d1_data got %0d bad want 0", bad_writes(dest)); end
        checks++; if (rd_addr_q.size() != 8 || bad_reads(src) != 0) begin
            errors++; $display("FAIL d1_reads got %0d reads want 8 contiguous", rd_addr_q.size()); end
        checks++; if (wr_cyc_q.size() == 0 || rd_cyc_q.size() == 0 || wr_cyc_q[0] - rd_cyc_q[0] != 2) begin
            errors++; $display("FAIL d1_latency got %0d want 2", (wr_cyc_q.size() > 0 && rd_cyc_q.size() > 0) ? wr_cyc_q[0] - rd_cyc_q[0] : -1); end
        checks++; if (done_q.size() != 1 || done_q[0] != last_wr() + 1) begin
            errors++; $display("FAIL d1_done got %0d pulses want 1 after last write %0d", done_q.size(), last_wr()); end
    endtask

    task automatic test_d5();
        bit to;
        gen_words(1, 1, 1);
        words_q[0] = 32'hFFFFFFFF;
        build_model(1, 1);
        start_cmd(1, 1, 7, 300);
        wait_done(600, to);
        checks++; if (to) begin errors++; $display("FAIL d5_timeout got timeout want done"); end
        checks++; if (wr_data_q.size() == 0 || wr_data_q[0] !== {4{24'd3225}}) begin
            errors++; $display("FAIL d5_write0 got %h want 4x3225", (wr_data_q.size() > 0) ? wr_data_q[0] : 96'h0); end
        checks++; if (wr_data_q.size() != 64 || bad_writes(300) != 0) begin
            errors++; $display("FAIL d5_data got %0d writes %0d bad want 64/0", wr_data_q.size(), bad_writes(300)); end
        checks++; if (wr_cyc_q.size() == 0 || rd_cyc_q.size() == 0 || wr_cyc_q[0] - rd_cyc_q[0] != 2) begin
            errors++; $display("FAIL d5_latency got %0d want 2", (wr_cyc_q.size() > 0 && rd_cyc_q.size() > 0) ? wr_cyc_q[0] - rd_cyc_q[0] : -1); end
    endtask

    task automatic test_d11();
        bit to;
        int n;
        words_q.delete();
        for (int i = 0; i < 176; i++) words_q.push_back(32'hFFFFFFFF);
        build_model(2, 2);
        start_cmd(2, 2, 1000, 5000);
        wait_done(1000, to);
        n = 0;
        for (int j = 0; j < wr_data_q.size(); j++) if (wr_data_q[j] !== {4{24'd3327}}) n++;
        checks++; if (to) begin errors++; $display("FAIL d11_timeout got timeout want done"); end
        checks++; if (wr_data_q.size() != 128 || n != 0) begin
            errors++; $display("FAIL d11_values got %0d writes %0d not 3327 want 128/0", wr_data_q.size(), n); end
        checks++; if (bad_writes(5000) != 0) begin errors++; $display("FAIL d11_addr got %0d bad want 0", bad_writes(5000)); end
        checks++; if (rd_addr_q.size() != 176 || bad_reads(1000) != 0) begin
            errors++; $display("FAIL d11_reads got %0d reads %0d bad want 176/0", rd_addr_q.size(), bad_reads(1000)); end
    endtask

    task automatic test_d12();
        bit to;
        int n;
        gen_words(3, 1, 1);
        words_q[0] = 32'h00000FFF;
        build_model(3, 1);
        start_cmd(3, 1, 20000, 40);
        wait_done(600, to);
        n = 0;
        for (int j = 0; j < wr_cyc_q.size(); j++)
            if (rd_cyc_q.size() == 0 || wr_cyc_q[j] - rd_cyc_q[0] != 3 + 3 * (j / 2) + (j % 2)) n++;
        checks++; if (to) begin errors++; $display("FAIL d12_timeout got timeout want done"); end
        checks++; if (wr_data_q.size() == 0 || wr_data_q[0] !== {72'h0, 24'd4095}) begin
            errors++; $display("FAIL d12_write0 got %h want coeff0=4095", (wr_data_q.size() > 0) ? wr_data_q[0] : 96'h0); end
        checks++; if (wr_data_q.size() != 64 || bad_writes(40) != 0) begin
            errors++; $display("FAIL d12_data got %0d writes %0d bad want 64/0", wr_data_q.size(), bad_writes(40)); end
        checks++; if (n != 0) begin errors++; $display("FAIL d12_cadence got %0d off-cadence writes want 0", n); end
        checks++; if (decode_error !== 1'b1) begin errors++; $display("FAIL d12_err_held got %b want 1", decode_error); end
        checks++; if (done_q.size() != 1 || done_q[0] != last_wr() + 1) begin
            errors++; $display("FAIL d12_done got %0d pulses want 1 after last write", done_q.size()); end
    endtask

    task automatic test_random();
        bit to;
        int m, np, npe, src, dest;
        for (int it = 0; it < 6; it++) begin
            m = $urandom_range(0, 3);
            np = $urandom_range(0, 4);
            npe = (np == 0) ? 1 : np;
            src = $urandom_range(0, AS - 1);
            dest = $urandom_range(0, AS - 1);
            gen_words(m, npe, 0);
            build_model(m, npe);
            start_cmd(m, np, src, dest);
            wait_done(2000, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got timeout want done", it); end
            checks++; if (wr_data_q.size() != 64 * npe || bad_writes(dest) != 0) begin
                errors++; $display("FAIL rand%0d_data m=%0d np=%0d got %0d writes %0d bad want %0d/0", it, m, np, wr_data_q.size(), bad_writes(dest), 64 * npe); end
            checks++; if (rd_addr_q.size() != 8 * dval(m) * npe || bad_reads(src) != 0) begin
                errors++; $display("FAIL rand%0d_reads got %0d want %0d", it, rd_addr_q.size(), 8 * dval(m) * npe); end
            checks++; if (decode_error !== exp_err) begin
                errors++; $display("FAIL rand%0d_err got %b want %b", it, decode_error, exp_err); end
            checks++; if (done_q.size() != 1 || done_q[0] != last_wr() + 1) begin
                errors++; $display("FAIL rand%0d_done got %0d pulses want 1", it, done_q.size()); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int nw;
        gen_words(1, 1, 0);
        start_cmd(1, 1, 50, 60);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (wr_cyc_q.size() > 20) break;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({api_rd_en, mem_wr_en, decompress_done, decode_error} !== 4'b0 ||
            {api_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin
            errors++; $display("FAIL midreset_outputs got %b %h %h want all 0",
                {api_rd_en, mem_wr_en, decompress_done, decode_error}, mem_wr_addr, mem_wr_data); end
        @(negedge clk);
        reset = 1'b0;
        nw = wr_cyc_q.size();
        repeat (40) @(negedge clk);
        checks++; if (done_q.size() != 0 || wr_cyc_q.size() != nw) begin
            errors++; $display("FAIL midreset_quiet got %0d done %0d extra writes want 0/0", done_q.size(), wr_cyc_q.size() - nw); end
        gen_words(1, 1, 0);
        build_model(1, 1);
        start_cmd(1, 1, 900, 77);
        wait_done(600, to);
        checks++; if (to || wr_data_q.size() != 64 || bad_writes(77) != 0) begin
            errors++; $display("FAIL midreset_rerun got %0d writes %0d bad want 64/0", wr_data_q.size(), bad_writes(77)); end
        checks++; if (rd_addr_q.size() == 0 || rd_addr_q[0] != 900 || bad_reads(900) != 0) begin
            errors++; $display("FAIL midreset_src got %0d want 900", (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1); end
    endtask

    task automatic test_zeroize();
        int nw;
        gen_words(3, 1, 1);
        words_q[0] = 32'h00000FFF;
        start_cmd(3, 1, 3000, 3100);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (wr_cyc_q.size() > 10) break;
        end
        checks++; if (decode_error !== 1'b1) begin errors++; $display("FAIL zero_pre_err got %b want 1", decode_error); end
        zeroize = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({api_rd_en, mem_wr_en, decompress_done, decode_error} !== 4'b0 || mem_wr_data !== '0) begin
            errors++; $display("FAIL zeroize_outputs got %b %h want all 0",
                {api_rd_en, mem_wr_en, decompress_done, decode_error}, mem_wr_data); end
        @(negedge clk);
        zeroize = 1'b0;
        nw = wr_cyc_q.size();
        repeat (30) @(negedge clk);
        checks++; if (done_q.size() != 0 || wr_cyc_q.size() != nw) begin
            errors++; $display("FAIL zeroize_quiet got %0d done want 0", done_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int dest, nr;
        dest = AS - 10;
        gen_words(0, 1, 0);
        build_model(0, 1);
        start_cmd(0, 1, 12345, dest);
        repeat (4) @(negedge clk);
        mode = 2'd3; num_poly = 3'd4; decompress_enable = 1'b1;
        @(negedge clk);
        decompress_enable = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (decompress_done) begin
                to = 1'b0;
                break;
            end
        end
        decompress_enable = 1'b1;
        @(negedge clk);
        decompress_enable = 1'b0;
        nr = rd_addr_q.size();
        repeat (10) @(negedge clk);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout got timeout want done"); end
        checks++; if (wr_data_q.size() != 64 || bad_writes(dest) != 0) begin
            errors++; $display("FAIL b2b_data got %0d writes %0d bad want 64/0", wr_data_q.size(), bad_writes(dest)); end
        checks++; if (wr_addr_q.size() < 11 || wr_addr_q[9] != AS - 1 || wr_addr_q[10] != 0) begin
            errors++; $display("FAIL b2b_wrap got %0d want 0 after 32767", (wr_addr_q.size() > 10) ? wr_addr_q[10] : -1); end
        checks++; if (nr != 8 || rd_addr_q.size() != 8) begin
            errors++; $display("FAIL b2b_ignored got %0d reads want 8", rd_addr_q.size()); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL b2b_done got %0d pulses want 1", done_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < AS; i++) api_mem[i] = '0;
        test_reset();
        test_d1();
        test_d5();
        test_d11();
        test_d12();
        test_random();
        test_reset_mid();
        test_zeroize();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
